i2c_slave_ctrl: RTL

Byte-level I2C slave protocol engine. It sits directly downstream of the START/STOP/SCL-edge detector and consumes its single-cycle pulses plus the synchronized SDA. It handles address match, register-pointer load, write/read bursts with pointer auto-increment, and ACK/NACK. It drives the SDA open-drain enable and a simple register-file port for the 16-channel PWM register bank.

---
 rtl/i2c_pkg.sv | 33 +++
 rtl/i2c_shift_reg.sv | 52 +++++
 rtl/i2c_slave_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C slave protocol engine: FSM state encoding,
// general-call constants and the ACK/NACK bus levels.
// -----------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR,
    ST_WR_ACK,
    ST_RD,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic [6:0] I2C_GC_ADDR  = 7'h00;
  localparam logic [7:0] I2C_GC_SWRST = 8'h06;

  // SDA levels seen on the bus for the acknowledge bit.
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // States in which the master drives a byte that the slave shifts in.
  function automatic logic is_rx_state(input i2c_state_e s);
    return (s inside {ST_ADDR, ST_PTR, ST_WR});
  endfunction

endpackage

// File: rtl/i2c_shift_reg.sv
// -----------------------------------------------------------------------------
// i2c_shift_reg
// 8-bit MSB-first shift register with a 3-bit bit counter.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   clr_i          : clear bit counter and byte_done (data kept)
//   ld_i/ld_data_i : parallel load (transmit byte), clears counter
//   rx_i, sda_i    : shift SDA in at the LSB, count one bit
//   tx_i           : shift left by one (next bit moves to bit 7), count one bit
//   data_o         : shift register contents
//   cnt_o          : bits shifted since the last clear/load (0..7)
//   byte_done_o    : set once 8 bits have been received
// Priority: clr > ld > rx > tx.
// -----------------------------------------------------------------------------
module i2c_shift_reg (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       clr_i,
  input  logic       ld_i,
  input  logic [7:0] ld_data_i,
  input  logic       rx_i,
  input  logic       sda_i,
  input  logic       tx_i,
  output logic [7:0] data_o,
  output logic [2:0] cnt_o,
  output logic       byte_done_o
);

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_o      <= '0;
      cnt_o       <= '0;
      byte_done_o <= 1'b0;
    end else if (clr_i) begin
      cnt_o       <= '0;
      byte_done_o <= 1'b0;
    end else if (ld_i) begin
      data_o      <= ld_data_i;
      cnt_o       <= '0;
      byte_done_o <= 1'b0;
    end else if (rx_i) begin
      data_o <= {data_o[6:0], sda_i};
      cnt_o  <= cnt_o + 3'd1;
      if (cnt_o == 3'd7) byte_done_o <= 1'b1;
    end else if (tx_i) begin
      data_o <= {data_o[6:0], 1'b0};
      cnt_o  <= cnt_o + 3'd1;
    end
  end

endmodule

// File: rtl/i2c_slave_ctrl.sv
// -----------------------------------------------------------------------------
// i2c_slave_ctrl
// Byte-level I2C slave engine driving a register-file port.
// Parameters:
//   SLAVE_ADDR : 7-bit device address
//   ADDR_W     : register pointer width (wraps modulo 2^ADDR_W)
// Ports:
//   clk_i, rst_n_i          : clock, asynchronous active-low reset
//   start_i, stop_i         : START/repeated-START and STOP pulses (1 clk)
//   scl_rise_i, scl_fall_i  : SCL edge pulses (1 clk)
//   sda_i                   : synchronized SDA level
//   sda_oe_o                : 1 = pull SDA low
//   reg_addr_o              : register pointer
//   reg_wdata_o, reg_we_o   : write data and 1-clk write strobe
//   reg_re_o, reg_rdata_i   : 1-clk read strobe; read data captured next clk
//   busy_o                  : engine not idle
//   sw_reset_o              : general-call software reset pulse
// Build option: define I2C_GEN_CALL_EN to ACK the general-call address (write
// only) and raise sw_reset_o on the software-reset byte 8'h06. Without it the
// general-call address is a mismatch and sw_reset_o is constant 0.
// -----------------------------------------------------------------------------
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h40,
  parameter int         ADDR_W     = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              scl_rise_i,
  input  logic              scl_fall_i,
  input  logic              sda_i,
  output logic              sda_oe_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [7:0]        reg_wdata_o,
  output logic              reg_we_o,
  output logic              reg_re_o,
  input  logic [7:0]        reg_rdata_i,
  output logic              busy_o,
  output logic              sw_reset_o
);

`ifdef I2C_GEN_CALL_EN
  localparam logic GC_EN = 1'b1;
`else
  localparam logic GC_EN = 1'b0;
`endif

  i2c_state_e        state_q;
  logic              rw_q;
  logic              gc_q;
  logic              sw_reset_q;
  logic [ADDR_W-1:0] ptr_q;

  logic [7:0] sr_data;
  logic [2:0] sr_cnt;
  logic       sr_done;
  logic       sr_clr, sr_ld, sr_rx, sr_tx;

  logic addr_hit, gc_hit;

  assign addr_hit   = (sr_data[7:1] == SLAVE_ADDR);
  assign gc_hit     = GC_EN && (sr_data == {I2C_GC_ADDR, 1'b0});
  assign reg_addr_o = ptr_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign sw_reset_o = GC_EN && sw_reset_q;

  // Shift register control. START/STOP always restart the bit counter; a
  // received byte is consumed (counter cleared) on the SCL fall that ends it.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    sr_clr = 1'b0;
    sr_ld  = 1'b0;
    sr_rx  = 1'b0;
    sr_tx  = 1'b0;
    if (start_i || stop_i) begin
      sr_clr = 1'b1;
    end else begin
      // Read data is returned the clock after the strobe.
      sr_ld = reg_re_o;
      if (scl_rise_i && is_rx_state(state_q) && !sr_done) sr_rx = 1'b1;
      if (scl_fall_i) begin
        if (is_rx_state(state_q) && sr_done) sr_clr = 1'b1;
        if (state_q == ST_RD) begin
          if (sr_cnt == 3'd7) sr_clr = 1'b1;
          else                sr_tx  = 1'b1;
        end
      end
    end
  end

  i2c_shift_reg u_shift (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clr_i      (sr_clr),
    .ld_i       (sr_ld),
    .ld_data_i  (reg_rdata_i),
    .rx_i       (sr_rx),
    .sda_i      (sda_i),
    .tx_i       (sr_tx),
    .data_o     (sr_data),
    .cnt_o      (sr_cnt),
    .byte_done_o(sr_done)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      rw_q        <= 1'b0;
      gc_q        <= 1'b0;
      sw_reset_q  <= 1'b0;
      ptr_q       <= '0;
      sda_oe_o    <= 1'b0;
      reg_wdata_o <= '0;
      reg_we_o    <= 1'b0;
      reg_re_o    <= 1'b0;
    end else begin
      reg_we_o   <= 1'b0;
      reg_re_o   <= 1'b0;
      sw_reset_q <= 1'b0;

      // Post-increment after a write, applied regardless of bus events.
      if (reg_we_o) ptr_q <= ptr_q + ADDR_W'(1);

      if (stop_i) begin
        state_q  <= ST_IDLE;
        sda_oe_o <= 1'b0;
      end else if (start_i) begin
        state_q  <= ST_ADDR;
        sda_oe_o <= 1'b0;
        gc_q     <= 1'b0;
      end else begin
        unique case (state_q)
          ST_ADDR: begin
            if (scl_fall_i && sr_done) begin
              if (addr_hit) begin
                state_q  <= ST_ADDR_ACK;
                sda_oe_o <= 1'b1;
                rw_q     <= sr_data[0];
                reg_re_o <= sr_data[0];
              end else if (gc_hit) begin
                state_q  <= ST_ADDR_ACK;
                sda_oe_o <= 1'b1;
                rw_q     <= 1'b0;
                gc_q     <= 1'b1;
              end else begin
                state_q <= ST_IGNORE;
              end
            end
          end

          ST_ADDR_ACK: begin
            if (scl_fall_i) begin
              if (rw_q) begin
                state_q  <= ST_RD;
                sda_oe_o <= ~sr_data[7];
              end else begin
                state_q  <= ST_PTR;
                sda_oe_o <= 1'b0;
              end
            end
          end

          ST_PTR: begin
            if (scl_fall_i && sr_done) begin
              if (gc_q) begin
                // General call: only the software-reset command is ACKed.
                if (sr_data == I2C_GC_SWRST) begin
                  state_q    <= ST_PTR_ACK;
                  sda_oe_o   <= 1'b1;
                  sw_reset_q <= 1'b1;
                end else begin
                  state_q <= ST_IGNORE;
                end
              end else begin
                ptr_q    <= ADDR_W'(sr_data);
                state_q  <= ST_PTR_ACK;
                sda_oe_o <= 1'b1;
              end
            end
          end

          ST_PTR_ACK: begin
            if (scl_fall_i) begin
              state_q  <= gc_q ? ST_IGNORE : ST_WR;
              sda_oe_o <= 1'b0;
            end
          end

          ST_WR: begin
            if (scl_fall_i && sr_done) begin
              state_q     <= ST_WR_ACK;
              sda_oe_o    <= 1'b1;
              reg_we_o    <= 1'b1;
              reg_wdata_o <= sr_data;
            end
          end

          ST_WR_ACK: begin
            if (scl_fall_i) begin
              state_q  <= ST_WR;
              sda_oe_o <= 1'b0;
            end
          end

          ST_RD: begin
            if (scl_fall_i) begin
              if (sr_cnt == 3'd7) begin
                state_q  <= ST_RD_ACK;
                sda_oe_o <= 1'b0;
              end else begin
                // Bit 6 becomes the MSB after this fall's shift.
                sda_oe_o <= ~sr_data[6];
              end
            end
          end

          ST_RD_ACK: begin
            if (scl_rise_i) begin
              if (sda_i == NACK) begin
                state_q <= ST_IGNORE;
              end else begin
                ptr_q    <= ptr_q + ADDR_W'(1);
                reg_re_o <= 1'b1;
              end
            end else if (scl_fall_i) begin
              state_q  <= ST_RD;
              sda_oe_o <= ~sr_data[7];
            end
          end

          default: ; // ST_IDLE, ST_IGNORE: wait for START/STOP
        endcase
      end
    end
  end

endmodule
